// File: rtl/vga_timing_gen.sv
// Raster timing generator with two selectable timing sets, advancing on a pixel clock-enable.
// All outputs are registered and describe the position held in h_q/v_q at the enabled edge.
module vga_timing_gen #(
    parameter int CW         = 11,
    parameter int H_ACTIVE_0 = 640,
    parameter int H_FP_0     = 16,
    parameter int H_SYNC_0   = 96,
    parameter int H_BP_0     = 48,
    parameter int V_ACTIVE_0 = 480,
    parameter int V_FP_0     = 10,
    parameter int V_SYNC_0   = 2,
    parameter int V_BP_0     = 33,
    parameter int H_ACTIVE_1 = 640,
    parameter int H_FP_1     = 24,
    parameter int H_SYNC_1   = 40,
    parameter int H_BP_1     = 128,
    parameter int V_ACTIVE_1 = 480,
    parameter int V_FP_1     = 9,
    parameter int V_SYNC_1   = 3,
    parameter int V_BP_1     = 28,
    parameter bit HS_POL     = 1'b0,
    parameter bit VS_POL     = 1'b0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pix_ce,
    input  logic          mode_sel,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [CW-1:0] x_px,
    output logic [CW-1:0] y_px,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic          active_mode
);

    localparam logic [CW-1:0] HA0  = CW'(H_ACTIVE_0);
    localparam logic [CW-1:0] HSS0 = CW'(H_ACTIVE_0 + H_FP_0);
    localparam logic [CW-1:0] HSE0 = CW'(H_ACTIVE_0 + H_FP_0 + H_SYNC_0);
    localparam logic [CW-1:0] HM0  = CW'(H_ACTIVE_0 + H_FP_0 + H_SYNC_0 + H_BP_0 - 1);
    localparam logic [CW-1:0] VA0  = CW'(V_ACTIVE_0);
    localparam logic [CW-1:0] VSS0 = CW'(V_ACTIVE_0 + V_FP_0);
    localparam logic [CW-1:0] VSE0 = CW'(V_ACTIVE_0 + V_FP_0 + V_SYNC_0);
    localparam logic [CW-1:0] VM0  = CW'(V_ACTIVE_0 + V_FP_0 + V_SYNC_0 + V_BP_0 - 1);
    localparam logic [CW-1:0] HA1  = CW'(H_ACTIVE_1);
    localparam logic [CW-1:0] HSS1 = CW'(H_ACTIVE_1 + H_FP_1);
    localparam logic [CW-1:0] HSE1 = CW'(H_ACTIVE_1 + H_FP_1 + H_SYNC_1);
    localparam logic [CW-1:0] HM1  = CW'(H_ACTIVE_1 + H_FP_1 + H_SYNC_1 + H_BP_1 - 1);
    localparam logic [CW-1:0] VA1  = CW'(V_ACTIVE_1);
    localparam logic [CW-1:0] VSS1 = CW'(V_ACTIVE_1 + V_FP_1);
    localparam logic [CW-1:0] VSE1 = CW'(V_ACTIVE_1 + V_FP_1 + V_SYNC_1);
    localparam logic [CW-1:0] VM1  = CW'(V_ACTIVE_1 + V_FP_1 + V_SYNC_1 + V_BP_1 - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] h_q, v_q, h_d, v_d;
    logic [CW-1:0] x_q, y_q, x_d, y_d;
    logic          mode_q, sel_s, origin_s;
    logic          hs_q, vs_q, de_q, ls_q, fs_q, vb_q;
    logic          hs_d, vs_d, de_d, ls_d, vb_d;
    logic [CW-1:0] ha_s, hss_s, hse_s, hm_s, va_s, vss_s, vse_s, vm_s;

    // Set selection: the (0,0) edge uses the freshly requested set, all others the latched one.
    always_comb begin
        origin_s = (h_q == ZERO) && (v_q == ZERO);
        sel_s    = origin_s ? mode_sel : mode_q;
        if (sel_s) begin
            ha_s = HA1; hss_s = HSS1; hse_s = HSE1; hm_s = HM1;
            va_s = VA1; vss_s = VSS1; vse_s = VSE1; vm_s = VM1;
        end else begin
            ha_s = HA0; hss_s = HSS0; hse_s = HSE0; hm_s = HM0;
            va_s = VA0; vss_s = VSS0; vse_s = VSE0; vm_s = VM0;
        end
    end

    // Decode of the position about to be emitted, plus counter advance.
    always_comb begin
        de_d = (h_q < ha_s) && (v_q < va_s);
        x_d  = de_d ? h_q : ZERO;
        y_d  = de_d ? v_q : ZERO;
        hs_d = ((h_q >= hss_s) && (h_q < hse_s)) ? HS_POL : ~HS_POL;
        vs_d = ((v_q >= vss_s) && (v_q < vse_s)) ? VS_POL : ~VS_POL;
        ls_d = (h_q == ZERO);
        vb_d = (h_q == ZERO) && (v_q == va_s);
        if (h_q == hm_s) begin
            h_d = ZERO;
            v_d = (v_q == vm_s) ? ZERO : v_q + ONE;
        end else begin
            h_d = h_q + ONE;
            v_d = v_q;
        end
    end

    // State and output registers; strobes drop on any edge without pix_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q    <= ZERO;
            v_q    <= ZERO;
            x_q    <= ZERO;
            y_q    <= ZERO;
            de_q   <= 1'b0;
            hs_q   <= ~HS_POL;
            vs_q   <= ~VS_POL;
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            vb_q   <= 1'b0;
            mode_q <= 1'b0;
        end else if (pix_ce) begin
            h_q    <= h_d;
            v_q    <= v_d;
            x_q    <= x_d;
            y_q    <= y_d;
            de_q   <= de_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            ls_q   <= ls_d;
            fs_q   <= origin_s;
            vb_q   <= vb_d;
            mode_q <= sel_s;
        end else begin
            ls_q   <= 1'b0;
            fs_q   <= 1'b0;
            vb_q   <= 1'b0;
        end
    end

    assign hsync        = hs_q;
    assign vsync        = vs_q;
    assign de           = de_q;
    assign x_px         = x_q;
    assign y_px         = y_q;
    assign line_start   = ls_q;
    assign frame_start  = fs_q;
    assign vblank_start = vb_q;
    assign active_mode  = mode_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen using a shrunk raster (set 0: 15x12, set 1: 16x11)
// and a second instance built with active-high sync polarity.
module tb_vga_timing_gen;

    localparam int CW = 11;

    logic clk = 1'b0;
    logic rst_n, pix_ce, mode_sel;
    logic hsync, vsync, de, line_start, frame_start, vblank_start, active_mode;
    logic hsync_b, vsync_b, de_b, ls_b, fs_b, vb_b, am_b;
    logic [CW-1:0] x_px, y_px, x_b, y_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(CW),
        .H_ACTIVE_0(8), .H_FP_0(2), .H_SYNC_0(3), .H_BP_0(2),
        .V_ACTIVE_0(6), .V_FP_0(2), .V_SYNC_0(2), .V_BP_0(2),
        .H_ACTIVE_1(8), .H_FP_1(1), .H_SYNC_1(4), .H_BP_1(3),
        .V_ACTIVE_1(6), .V_FP_1(1), .V_SYNC_1(3), .V_BP_1(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode_sel(mode_sel),
        .hsync(hsync), .vsync(vsync), .de(de), .x_px(x_px), .y_px(y_px),
        .line_start(line_start), .frame_start(frame_start),
        .vblank_start(vblank_start), .active_mode(active_mode)
    );

    vga_timing_gen #(
        .CW(CW),
        .H_ACTIVE_0(8), .H_FP_0(2), .H_SYNC_0(3), .H_BP_0(2),
        .V_ACTIVE_0(6), .V_FP_0(2), .V_SYNC_0(2), .V_BP_0(2),
        .H_ACTIVE_1(8), .H_FP_1(1), .H_SYNC_1(4), .H_BP_1(3),
        .V_ACTIVE_1(6), .V_FP_1(1), .V_SYNC_1(3), .V_BP_1(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_pos (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .mode_sel(mode_sel),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .x_px(x_b), .y_px(y_b),
        .line_start(ls_b), .frame_start(fs_b),
        .vblank_start(vb_b), .active_mode(am_b)
    );

    // Observation vector: {de,hsync,vsync,hsync_b,vsync_b,ls,fs,vb,mode,x,y}
    function automatic logic [30:0] obs();
        return {de, hsync, vsync, hsync_b, vsync_b, line_start, frame_start,
                vblank_start, active_mode, x_px, y_px};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [30:0] exp_v;
        rst_n = 1'b0; pix_ce = 1'b1; mode_sel = 1'b1;
        repeat (3) cyc();
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL reset_state got=%h exp=%h", obs(), exp_v);
        end
        mode_sel = 1'b0;
        rst_n = 1'b1;
    endtask

    // Full set-0 frame; mode_sel is raised mid-frame and must not take effect.
    task automatic test_set0_frame();
        int h, v, ls_cnt, de_cnt;
        logic de_e, hs_e, vs_e;
        logic [30:0] exp_v;
        ls_cnt = 0; de_cnt = 0;
        pix_ce = 1'b1;
        for (int k = 0; k < 180; k++) begin
            if (k == 50) mode_sel = 1'b1;
            cyc();
            h = k % 15; v = k / 15;
            de_e = (h < 8) && (v < 6);
            hs_e = (h >= 10) && (h < 13);
            vs_e = (v >= 8) && (v < 10);
            exp_v = {de_e, ~hs_e, ~vs_e, hs_e, vs_e, (h == 0), (k == 0), (h == 0 && v == 6),
                     1'b0, de_e ? CW'(h) : 11'd0, de_e ? CW'(v) : 11'd0};
            tests++;
            if (obs() !== exp_v) begin
                fails++;
                $display("FAIL set0_pos h=%0d v=%0d got=%h exp=%h", h, v, obs(), exp_v);
            end
            if (line_start) ls_cnt++;
            if (de) de_cnt++;
        end
        tests++;
        if (ls_cnt !== 12 || de_cnt !== 48) begin
            fails++;
            $display("FAIL set0_counts ls=%0d de=%0d exp ls=12 de=48", ls_cnt, de_cnt);
        end
    endtask

    // Set-1 frame picked up at (0,0); mode_sel dropped mid-frame.
    task automatic test_mode_switch();
        int h, v;
        logic de_e, hs_e, vs_e;
        logic [30:0] exp_v;
        pix_ce = 1'b1;
        for (int k = 0; k < 176; k++) begin
            if (k == 60) mode_sel = 1'b0;
            cyc();
            h = k % 16; v = k / 16;
            de_e = (h < 8) && (v < 6);
            hs_e = (h >= 9) && (h < 13);
            vs_e = (v >= 7) && (v < 10);
            exp_v = {de_e, ~hs_e, ~vs_e, hs_e, vs_e, (h == 0), (k == 0), (h == 0 && v == 6),
                     1'b1, de_e ? CW'(h) : 11'd0, de_e ? CW'(v) : 11'd0};
            tests++;
            if (obs() !== exp_v) begin
                fails++;
                $display("FAIL set1_pos h=%0d v=%0d got=%h exp=%h", h, v, obs(), exp_v);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [30:0] exp_v;
        cyc();
        exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11'd0, 11'd0};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL back_to_back_origin got=%h exp=%h", obs(), exp_v);
        end
    endtask

    // pix_ce every other clk: positions advance on enabled edges only, strobes one clk wide.
    task automatic test_clock_enable();
        int h, v, ls_cnt;
        logic de_e;
        logic [30:0] exp_v, held;
        ls_cnt = 0;
        for (int k = 1; k <= 30; k++) begin
            pix_ce = 1'b1;
            cyc();
            h = k % 15; v = k / 15;
            de_e = (h < 8) && (v < 6);
            exp_v = {de_e, 1'b1, 1'b1, 1'b0, 1'b0, (h == 0), 1'b0, 1'b0, 1'b0,
                     de_e ? CW'(h) : 11'd0, de_e ? CW'(v) : 11'd0};
            if (h >= 10 && h < 13) exp_v[29] = 1'b0;
            if (h >= 10 && h < 13) exp_v[27] = 1'b1;
            tests++;
            if (obs() !== exp_v) begin
                fails++;
                $display("FAIL ce_step h=%0d v=%0d got=%h exp=%h", h, v, obs(), exp_v);
            end
            if (line_start) ls_cnt++;
            held = exp_v;
            held[25:23] = 3'b000;
            pix_ce = 1'b0;
            cyc();
            tests++;
            if (obs() !== held) begin
                fails++;
                $display("FAIL ce_hold h=%0d v=%0d got=%h exp=%h", h, v, obs(), held);
            end
            if (line_start) ls_cnt++;
        end
        tests++;
        if (ls_cnt !== 2) begin
            fails++;
            $display("FAIL ce_line_strobes got=%0d exp=2", ls_cnt);
        end
    endtask

    task automatic test_async_reset();
        logic [30:0] exp_v;
        pix_ce = 1'b1;
        repeat (3) cyc();
        exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd3, 11'd2};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL pre_reset_pos got=%h exp=%h", obs(), exp_v);
        end
        mode_sel = 1'b1;
        rst_n = 1'b0;
        #2;
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL async_reset got=%h exp=%h", obs(), exp_v);
        end
        repeat (2) cyc();
        pix_ce = 1'b0;
        rst_n = 1'b1;
        cyc();
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL release_no_strobe got=%h exp=%h", obs(), exp_v);
        end
        pix_ce = 1'b1;
        cyc();
        exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 11'd0, 11'd0};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL restart_origin got=%h exp=%h", obs(), exp_v);
        end
        cyc();
        exp_v = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 11'd1, 11'd0};
        tests++;
        if (obs() !== exp_v) begin
            fails++;
            $display("FAIL restart_next got=%h exp=%h", obs(), exp_v);
        end
    endtask

    initial begin
        rst_n = 1'b0; pix_ce = 1'b0; mode_sel = 1'b0;
        test_reset();
        test_set0_frame();
        test_mode_switch();
        test_back_to_back();
        test_clock_enable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
